// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - XNOR LFSR tap table, next-word function and checker state encoding
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  // XNOR tap masks (bit k-1 set for tap k); msb tap is always w[width-1]
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] t;
    case (width)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] lfsr_next(input int width, input logic [31:0] word);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    fb   = ~(^(word & lfsr_taps(width)));
    return ((word << 1) | {31'b0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// rtl/lfsr_sat_counter.sv - saturating accumulator with synchronous clear
module lfsr_sat_counter #(
  parameter int CNT_W = 16,
  parameter int INC_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [INC_W-1:0] i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] base;
  logic [INC_W-1:0] add;
  logic [SUM_W-1:0] sum;

  // Clear replaces the base rather than the result, so a same-cycle increment survives
  always_comb begin
    base    = i_clear ? '0 : count_q;
    add     = i_en ? i_inc : '0;
    sum     = SUM_W'(base) + SUM_W'(add);
    count_d = (sum > SUM_W'(MAX_CNT)) ? MAX_CNT : sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising receive checker for the XNOR LFSR pattern
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic                i_clear_errors,
  output logic                o_locked,
  output logic                o_error,
  output logic [CNT_W-1:0]    o_word_err_count,
  output logic [CNT_W-1:0]    o_bit_err_count,
  output logic                o_period_done
);

  if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
    $error("lfsr_checker: NUM_BITS must be within 3..32");
  end
  if (LOCK_COUNT < 1 || LOSS_COUNT < 1) begin : g_bad_counts
    $error("lfsr_checker: LOCK_COUNT and LOSS_COUNT must be >= 1");
  end

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam int POP_W   = $clog2(NUM_BITS + 1);

  localparam logic [31:0]         TAPS_FULL   = lfsr_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS        = TAPS_FULL[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] ALL_ONES    = '1;
  localparam logic [NUM_BITS-1:0] PERIOD_LAST = {{(NUM_BITS-1){1'b1}}, 1'b0};
  localparam logic [MATCH_W-1:0]  LOCK_LAST   = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]   LOSS_LAST   = MISS_W'(LOSS_COUNT - 1);

  function automatic logic [NUM_BITS-1:0] step_word(input logic [NUM_BITS-1:0] w);
    return {w[NUM_BITS-2:0], ~(^(w & TAPS))};
  endfunction

  lfsr_state_t         state_q, state_d;
  logic [NUM_BITS-1:0] ref_q, ref_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [NUM_BITS-1:0] period_q, period_d;
  logic                error_q, error_d;
  logic                period_done_q, period_done_d;
  logic                err_en;
  logic [NUM_BITS-1:0] diff;
  logic [POP_W-1:0]    pop;

  always_comb begin
    diff = i_data ^ ref_q;
    pop  = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    ref_d         = ref_q;
    match_d       = match_q;
    miss_d        = miss_q;
    period_d      = period_q;
    error_d       = 1'b0;
    period_done_d = 1'b0;
    err_en        = 1'b0;
    if (i_valid) begin
      case (state_q)
        SEARCH: begin
          if (i_data != ALL_ONES) begin
            ref_d   = step_word(i_data);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (i_data == ALL_ONES) begin
            state_d = SEARCH;
          end else if (i_data == ref_q) begin
            ref_d = step_word(ref_q);
            if (match_q == LOCK_LAST) begin
              state_d  = LOCKED;
              match_d  = '0;
              miss_d   = '0;
              period_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            ref_d   = step_word(i_data);
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: once locked the reference only ever advances from itself
          ref_d = step_word(ref_q);
          if (period_q == PERIOD_LAST) begin
            period_done_d = 1'b1;
            period_d      = '0;
          end else begin
            period_d = period_q + 1'b1;
          end
          if (i_data != ref_q) begin
            error_d = 1'b1;
            err_en  = 1'b1;
            if (miss_q == LOSS_LAST) begin
              state_d = SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= SEARCH;
      ref_q         <= '0;
      match_q       <= '0;
      miss_q        <= '0;
      period_q      <= '0;
      error_q       <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_q         <= ref_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      period_q      <= period_d;
      error_q       <= error_d;
      period_done_q <= period_done_d;
    end
  end

  lfsr_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_word_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear_errors),
    .i_en    (err_en),
    .i_inc   (1'b1),
    .o_count (o_word_err_count)
  );

  lfsr_sat_counter #(.CNT_W(CNT_W), .INC_W(POP_W)) u_bit_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear_errors),
    .i_en    (err_en),
    .i_inc   (pop),
    .o_count (o_bit_err_count)
  );

  assign o_locked      = (state_q == LOCKED);
  assign o_error       = error_q;
  assign o_period_done = period_done_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - table vectors, corner sequences and random stream vs reference model
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] data = 4'h0;
  logic       clear_errors = 1'b0;
  logic       locked, error, period_done;
  logic [3:0] word_err, bit_err;

  int tests = 0;
  int fails = 0;

  lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(3), .LOSS_COUNT(4), .CNT_W(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid          (valid),
    .i_data           (data),
    .i_clear_errors   (clear_errors),
    .o_locked         (locked),
    .o_error          (error),
    .o_word_err_count (word_err),
    .o_bit_err_count  (bit_err),
    .o_period_done    (period_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       c;
    logic       lk;
    logic       er;
    logic [3:0] we;
    logic [3:0] be;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [3:0] d, input logic c,
                              input logic lk, input logic er, input int we, input int be);
    vec_t x;
    x.v = v; x.d = d; x.c = c; x.lk = lk; x.er = er; x.we = 4'(we); x.be = 4'(be);
    tbl.push_back(x);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next pattern word from the generator's rule: shift left, feed back XNOR of bits 3 and 2
  function automatic int nxt(input int w);
    int fb;
    fb = (((w / 8) % 2) == ((w / 4) % 2)) ? 1 : 0;
    return ((w * 2) % 16) + fb;
  endfunction

  function automatic int ones(input int w);
    return (w % 2) + ((w / 2) % 2) + ((w / 4) % 2) + ((w / 8) % 2);
  endfunction

  task automatic drive(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    valid = v; data = d; clear_errors = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; clear_errors = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_word"}, word_err, 0);
    check({tag, "_bit"}, bit_err, 0);
    check({tag, "_pd"}, period_done, 0);
  endtask

  // Reference model: plain arithmetic over the checker's rules
  int m_mode;  // 0 hunting, 1 confirming, 2 locked
  int m_ref, m_match, m_miss, m_words, m_word, m_bit;
  int m_err, m_pd;

  task automatic model_reset();
    m_mode = 0; m_ref = 0; m_match = 0; m_miss = 0; m_words = 0;
    m_word = 0; m_bit = 0; m_err = 0; m_pd = 0;
  endtask

  task automatic model_step(input int v, input int d, input int c);
    int winc, binc;
    winc = 0; binc = 0; m_err = 0; m_pd = 0;
    if (v != 0) begin
      if (m_mode == 0) begin
        if (d != 15) begin m_ref = nxt(d); m_match = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == 15) m_mode = 0;
        else if (d == m_ref) begin
          m_ref = nxt(m_ref);
          m_match = m_match + 1;
          if (m_match == 3) begin m_mode = 2; m_miss = 0; m_words = 0; end
        end else begin
          m_ref = nxt(d); m_match = 0;
        end
      end else begin
        if (d != m_ref) begin
          m_err = 1; winc = 1; binc = ones(d ^ m_ref);
          m_miss = m_miss + 1;
          if (m_miss == 4) m_mode = 0;
        end else m_miss = 0;
        m_words = m_words + 1;
        if (m_words == 15) begin m_pd = 1; m_words = 0; end
        m_ref = nxt(m_ref);
      end
    end
    m_word = ((c != 0) ? 0 : m_word) + winc;
    if (m_word > 15) m_word = 15;
    m_bit = ((c != 0) ? 0 : m_bit) + binc;
    if (m_bit > 15) m_bit = 15;
  endtask

  initial begin
    int r, pulses;

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 4'(i * 5), 1'b0);
    check_all_zero("idle");

    // Lock, single error with flywheel, gap, clear, loss of lock, all-ones in search
    add(1, 4'b0000, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 0, 0, 0, 0);
    add(1, 4'b0011, 0, 0, 0, 0, 0);
    add(1, 4'b0111, 0, 1, 0, 0, 0);
    add(1, 4'b1110, 0, 1, 0, 0, 0);
    add(1, 4'b1100, 0, 1, 1, 1, 1);
    add(1, 4'b1011, 0, 1, 0, 1, 1);
    add(0, 4'b1111, 0, 1, 0, 1, 1);
    add(1, 4'b0110, 0, 1, 0, 1, 1);
    add(0, 4'b0000, 1, 1, 0, 0, 0);
    add(1, 4'b0000, 0, 1, 1, 1, 2);
    add(1, 4'b0000, 0, 1, 1, 2, 4);
    add(1, 4'b0000, 0, 1, 1, 3, 5);
    add(1, 4'b0000, 0, 0, 1, 4, 7);
    add(1, 4'b1111, 0, 0, 0, 4, 7);
    add(1, 4'b1111, 0, 0, 0, 4, 7);
    add(1, 4'b0001, 0, 0, 0, 4, 7);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      check($sformatf("vec%0d_error", i), error, tbl[i].er);
      check($sformatf("vec%0d_word", i), word_err, tbl[i].we);
      check($sformatf("vec%0d_bit", i), bit_err, tbl[i].be);
      check($sformatf("vec%0d_pd", i), period_done, 0);
    end

    // Period pulse after exactly 15 clean locked words
    do_reset();
    drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0); drive(1, 4'b0111, 0);
    check("period_lock", locked, 1);
    r = 4'b1110;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      drive(1, 4'(r), 0);
      if (period_done) pulses++;
      check($sformatf("period_w%0d", k), period_done, (k == 15) ? 1 : 0);
      r = nxt(r);
    end
    check("period_pulses", pulses, 1);
    check("period_errs", word_err, 0);

    // Alternate bad/good words: stays locked, counters clamp at 15
    for (int k = 0; k < 20; k++) begin
      drive(1, 4'(r ^ 1), 0);
      r = nxt(r);
      drive(1, 4'(r), 0);
      r = nxt(r);
      check($sformatf("sat_word%0d", k), word_err, (k + 1 > 15) ? 15 : k + 1);
      check($sformatf("sat_bit%0d", k), bit_err, (k + 1 > 15) ? 15 : k + 1);
    end
    check("sat_locked", locked, 1);

    // Clear coincident with an error keeps that error
    drive(1, 4'(r ^ 3), 1);
    r = nxt(r);
    check("clr_word", word_err, 1);
    check("clr_bit", bit_err, 2);
    check("clr_error", error, 1);

    // Asynchronous reset while locked
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("async");
    @(negedge clk);
    rst = 1'b0;

    // Randomised stream against the reference model
    model_reset();
    for (int n = 0; n < 600; n++) begin
      int v, d, c, sel;
      sel = $urandom_range(0, 99);
      v = (sel < 88) ? 1 : 0;
      if (sel < 72 && m_mode != 0) d = m_ref;
      else if (sel < 80) d = $urandom_range(0, 15);
      else if (sel < 84) d = 15;
      else d = (m_mode != 0) ? (m_ref ^ $urandom_range(1, 15)) : $urandom_range(0, 14);
      c = ($urandom_range(0, 29) == 0) ? 1 : 0;
      drive(1'(v), 4'(d), 1'(c));
      model_step(v, d, c);
      check($sformatf("rnd%0d_locked", n), locked, (m_mode == 2) ? 1 : 0);
      check($sformatf("rnd%0d_error", n), error, m_err);
      check($sformatf("rnd%0d_word", n), word_err, m_word);
      check($sformatf("rnd%0d_bit", n), bit_err, m_bit);
      check($sformatf("rnd%0d_pd", n), period_done, m_pd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
